// File: rtl/spi_master_mc.sv
// spi_master_mc: single-word full-duplex SPI master.
//
// The CPOL/CPHA mode, clock divider, slave index and bit order are all
// captured when a transfer starts, so they can change at any time between
// transfers.
//
// Every phase step lasts div+1 clk cycles and is timed by a down-counter.
//
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   cs, rd, wr      host strobes. cs&wr&~rd starts a transfer;
//                   cs&rd clears the done and ovr flags.
//   din             word to transmit
//   mode            {CPOL,CPHA}
//   div             half-period of sclk, in clk cycles, minus one
//   ss_sel          index of the slave-select line to drive low
//   lsb_first       1 = bit 0 is shifted first
//   dout            last received word
//   done            sticky flag, set when a transfer completes
//   busy            high while a transfer is in progress
//   ovr             sticky flag, set by a start request while busy
//   miso            serial data in
//   mosi            serial data out
//   sclk            SPI clock
//   ss_n            active-low slave selects
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sclk follows mode[1]; waiting for a start request
// SETUP | slave selected; one step passes before the first sclk edge
// XFER  | sclk toggles at the end of each step until 2*DWIDTH edges
// HOLD  | one step with sclk at CPOL, then deselect and publish dout
module spi_master_mc #(
  parameter int DWIDTH = 8,
  parameter int NCS    = 4,
  parameter int DIVW   = 8,
  parameter int SSW    = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  input  logic [1:0]        mode,
  input  logic [DIVW-1:0]   div,
  input  logic [SSW-1:0]    ss_sel,
  input  logic              lsb_first,
  output logic [DWIDTH-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              ovr,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NCS-1:0]    ss_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int             EW        = $clog2(2 * DWIDTH + 1);
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DWIDTH);

  logic [1:0]        state;
  logic [DIVW-1:0]   cnt;
  logic [DIVW-1:0]   div_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [EW-1:0]     edge_cnt;
  logic [DWIDTH-1:0] tx_sh;
  logic [DWIDTH-1:0] rx_sh;

  logic              start_req;
  logic              rd_clr;
  logic              step_end;
  logic [EW-1:0]     edge_num;
  logic              leading;
  logic              do_shift;
  logic              do_sample;
  logic              finish;
  logic [NCS-1:0]    sel_n;

  function automatic logic first_bit(input logic [DWIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DWIDTH-1];
  endfunction

  function automatic logic [DWIDTH-1:0] shift_word(input logic [DWIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // A read strobe always wins over a write strobe in the same cycle.
  assign start_req = cs & wr & ~rd;
  assign rd_clr    = cs & rd;
  assign step_end  = (cnt == '0);
  assign edge_num  = edge_cnt + 1'b1;
  // Odd-numbered edges move sclk away from CPOL.
  assign leading   = edge_num[0];
  assign finish    = (state == HOLD) && step_end;
  assign busy      = (state != IDLE);

  // CPHA=0 presents its first bit before edge 1. It then shifts on trailing
  // edges, except the last one, because no bit is left to send after it.
  always_comb begin
    do_shift  = 1'b0;
    do_sample = 1'b0;
    if (((state == SETUP) || (state == XFER)) && step_end) begin
      if (cpha_q) begin
        do_shift  = leading;
        do_sample = ~leading;
      end else begin
        do_shift  = ~leading && (edge_num != LAST_EDGE);
        do_sample = leading;
      end
    end
  end

  // Out-of-range slave indices select nothing; the transfer still runs.
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NCS; i++) begin
      if (int'(ss_sel) == i) sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      dout     <= '0;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      ss_n     <= '1;
    end else begin
      case (state)
        IDLE: begin
          sclk <= mode[1];
          mosi <= 1'b0;
          if (start_req) begin
            state    <= SETUP;
            cnt      <= div;
            div_q    <= div;
            cpha_q   <= mode[0];
            lsb_q    <= lsb_first;
            edge_cnt <= '0;
            rx_sh    <= '0;
            ss_n     <= sel_n;
            if (!mode[0]) begin
              mosi  <= first_bit(din, lsb_first);
              tx_sh <= shift_word(din, lsb_first);
            end else begin
              tx_sh <= din;
            end
          end
        end
        SETUP, XFER: begin
          if (step_end) begin
            cnt      <= div_q;
            sclk     <= ~sclk;
            edge_cnt <= edge_num;
            state    <= (edge_num == LAST_EDGE) ? HOLD : XFER;
            if (do_shift) begin
              mosi  <= first_bit(tx_sh, lsb_q);
              tx_sh <= shift_word(tx_sh, lsb_q);
            end
            if (do_sample) begin
              rx_sh <= lsb_q ? {miso, rx_sh[DWIDTH-1:1]} : {rx_sh[DWIDTH-2:0], miso};
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (step_end) begin
            state <= IDLE;
            ss_n  <= '1;
            dout  <= rx_sh;
            mosi  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Setting a flag takes priority over a host clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (finish)
        done <= 1'b1;
      else if ((start_req && (state == IDLE)) || rd_clr)
        done <= 1'b0;

      if (start_req && (state != IDLE))
        ovr <= 1'b1;
      else if (rd_clr)
        ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
module tb_spi_master_mc;
  localparam int DW   = 8;
  localparam int NCS  = 4;
  localparam int DIVW = 8;
  localparam int SSW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [DW-1:0]   din = '0;
  logic [1:0]      mode = 2'b00;
  logic [DIVW-1:0] div = '0;
  logic [SSW-1:0]  ss_sel = '0;
  logic            lsb_first = 1'b0;
  logic [DW-1:0]   dout;
  logic            done, busy, ovr;
  logic            miso, mosi, sclk;
  logic [NCS-1:0]  ss_n;

  logic            loop_en = 1'b1;
  logic            s_miso = 1'b0;
  logic            s_cpol = 1'b0, s_cpha = 1'b0;
  logic [7:0]      s_sh = '0, s_rx = '0;
  logic [7:0]      mosi_log = '0;
  int              rise_cnt = 0;
  int              ss_low = 0;
  int              cyc = 0;
  int              total = 0, bad = 0;
  logic            mon_done_d = 1'b0;

  typedef struct {logic [7:0] data; int t_done;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  assign miso = loop_en ? mosi : s_miso;

  spi_master_mc #(.DWIDTH(DW), .NCS(NCS), .DIVW(DIVW), .SSW(SSW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .din(din), .mode(mode),
    .div(div), .ss_sel(ss_sel), .lsb_first(lsb_first), .dout(dout),
    .done(done), .busy(busy), .ovr(ovr), .miso(miso), .mosi(mosi),
    .sclk(sclk), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every rising done consumes one expected word.
  initial forever begin
    @(negedge clk);
    if (done && !mon_done_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("dout", dout, mon_e.data);
        check("done_cycle", cyc, mon_e.t_done);
      end
    end
    mon_done_d = done;
  end

  initial forever begin
    @(negedge clk);
    if (ss_n != 4'hF) ss_low++;
  end

  initial forever begin
    @(posedge sclk);
    mosi_log = {mosi_log[6:0], mosi};
    rise_cnt++;
  end

  // Slave on ss_n[0]: MSB first, always returns 8'h3C.
  initial forever begin
    @(negedge ss_n[0]);
    s_sh = 8'h3C;
    s_rx = '0;
    if (!s_cpha) begin
      s_miso = s_sh[7];
      s_sh   = s_sh << 1;
    end
  end

  initial forever begin
    @(sclk);
    if (!ss_n[0]) begin
      if ((sclk != s_cpol) ^ s_cpha) begin
        s_rx = {s_rx[6:0], mosi};
      end else begin
        s_miso = s_sh[7];
        s_sh   = s_sh << 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input logic [1:0] m, input logic [7:0] d, input logic [2:0] s, input logic l);
    @(posedge clk); #1;
    mode = m; div = d; ss_sel = s; lsb_first = l;
    s_cpol = m[1]; s_cpha = m[0];
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic start(input logic [7:0] data, output int t0);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; din = data;
    @(posedge clk); #1;
    t0 = cyc;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic expect_word(input logic [7:0] data, input int t_done);
    exp_t e;
    e.data = data;
    e.t_done = t_done;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    int t0, ss0, r0;
    logic [1:0] mm;

    #12;
    check("rst_dout", dout, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_ss_n", ss_n, 4'hF);
    rst = 1'b1;

    // mode 0, div 0, loopback
    loop_en = 1'b1;
    cfg(2'b00, 8'd0, 3'd0, 1'b0);
    ss0 = ss_low; r0 = rise_cnt;
    start(8'hA5, t0);
    expect_word(8'hA5, t0 + 17);
    check("t1_busy", busy, 1'b1);
    check("t1_ss_n_active", ss_n, 4'b1110);
    wait_done(40, "t1");
    check("t1_ss_low_cycles", ss_low - ss0, 17);
    check("t1_sclk_rises", rise_cnt - r0, 8);
    check("t1_mosi_bits", mosi_log, 8'hA5);
    check("t1_busy_clear", busy, 1'b0);
    check("t1_ss_n_idle", ss_n, 4'hF);

    // modes 1..3 against the slave model, div 3
    loop_en = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      mm = 2'(m);
      cfg(mm, 8'd3, 3'd0, 1'b0);
      check("mode_idle_sclk", sclk, mm[1]);
      start(8'hC3, t0);
      expect_word(8'h3C, t0 + 68);
      wait_done(100, "mode");
      check("mode_slave_rx", s_rx, 8'hC3);
      check("mode_end_sclk", sclk, mm[1]);
    end
    loop_en = 1'b1;

    // LSB first
    cfg(2'b00, 8'd0, 3'd0, 1'b1);
    start(8'h01, t0);
    expect_word(8'h01, t0 + 17);
    wait_done(40, "lsb");
    check("lsb_mosi_bits", mosi_log, 8'h80);

    // slave select 2, then out-of-range 5
    cfg(2'b00, 8'd0, 3'd2, 1'b0);
    start(8'h5A, t0);
    expect_word(8'h5A, t0 + 17);
    repeat (5) @(negedge clk);
    check("sel2_ss_n", ss_n, 4'b1011);
    wait_done(40, "sel2");
    check("sel2_ss_n_idle", ss_n, 4'hF);
    cfg(2'b00, 8'd0, 3'd5, 1'b0);
    ss0 = ss_low;
    start(8'h3E, t0);
    expect_word(8'h3E, t0 + 17);
    repeat (5) @(negedge clk);
    check("sel5_ss_n", ss_n, 4'hF);
    wait_done(40, "sel5");
    check("sel5_ss_low_cycles", ss_low - ss0, 0);

    // overrun at cycle 5, then host read clears flags
    cfg(2'b00, 8'd0, 3'd0, 1'b0);
    start(8'h96, t0);
    expect_word(8'h96, t0 + 17);
    repeat (4) @(posedge clk);
    #1;
    cs = 1'b1; wr = 1'b1; din = 8'hFF;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
    check("ovr_set", ovr, 1'b1);
    check("ovr_busy", busy, 1'b1);
    wait_done(40, "ovr");
    check("ovr_mosi_bits", mosi_log, 8'h96);
    check("ovr_sticky", ovr, 1'b1);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    check("rd_clr_done", done, 1'b0);
    check("rd_clr_ovr", ovr, 1'b0);

    // reset after edge 7
    start(8'h69, t0);
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_sclk", sclk, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_ss_n", ss_n, 4'hF);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    cfg(2'b00, 8'd0, 3'd0, 1'b0);
    start(8'hE7, t0);
    expect_word(8'hE7, t0 + 17);
    wait_done(40, "after_rst");
    check("after_rst_mosi_bits", mosi_log, 8'hE7);

    // maximum divider
    cfg(2'b00, 8'd255, 3'd0, 1'b0);
    start(8'h5C, t0);
    expect_word(8'h5C, t0 + 17 * 256);
    wait_done(4500, "maxdiv");

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
